// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: register address width and
// the {rd, data} record carried by the long-path result buffer.
package wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Canonical 32-bit record; the top re-declares the same layout at XLEN.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [31:0]           data;
  } wb_entry_t;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Decode, execute/memory and register-file write signals of the write-back stage.
interface wb_scoreboard_if
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic                  issue_valid;
  logic                  issue_long;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] src1;
  logic [REG_ADDR_W-1:0] src2;
  logic                  stall;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;

  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;

  logic                  write;
  logic [REG_ADDR_W-1:0] WR;
  logic [XLEN-1:0]       WD;

  modport master (
    output issue_valid, issue_long, issue_rd, src1, src2,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  stall, mem_ready, write, WR, WD
  );

  modport slave (
    input  issue_valid, issue_long, issue_rd, src1, src2,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output stall, mem_ready, write, WR, WD
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Power-of-two deep FIFO buffering long-path results until the write port is free.
module wb_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign pop_ok  = pop & !empty;
  // A full buffer may still take a push when the head leaves in the same cycle.
  assign push_ok = push & ((count != CW'(DEPTH)) | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Write-back arbiter (ALU first, then buffered long results) driving the
// register file write port, plus the busy scoreboard that stalls decode.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned LQ_DEPTH = 2
) (
  input logic            clk,
  input logic            reset,
  wb_scoreboard_if.slave bus
);

  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  entry_t                push_entry;
  entry_t                head;
  logic [EW-1:0]         head_bits;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;
  logic                  mem_ready;
  logic                  stall;
  logic                  issue_set;
  logic [31:0]           busy;
  logic [31:0]           busy_next;
  logic                  write_q;
  logic [REG_ADDR_W-1:0] wr_q;
  logic [XLEN-1:0]       wd_q;

  assign mem_ready  = (count < CW'(LQ_DEPTH));
  assign push       = bus.mem_valid & mem_ready;
  assign pop        = !bus.alu_valid & !empty;
  assign push_entry = '{rd: bus.mem_rd, data: bus.mem_data};
  assign head       = entry_t'(head_bits);

  wb_result_fifo #(
    .WIDTH (EW),
    .DEPTH (LQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_bits),
    .empty (empty),
    .count (count)
  );

  assign stall     = bus.issue_valid &
                     (busy[bus.src1] | busy[bus.src2] | busy[bus.issue_rd]);
  assign issue_set = bus.issue_valid & !stall & bus.issue_long &
                     (bus.issue_rd != REG_ZERO);

  // Clear is applied before set so a same-register set wins.
  always_comb begin
    busy_next = busy;
    if (pop && head.rd != REG_ZERO) busy_next[head.rd] = 1'b0;
    if (issue_set)                  busy_next[bus.issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Destination-0 writes are suppressed but leave WR/WD holding the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      wr_q    <= '0;
      wd_q    <= '0;
    end else if (bus.alu_valid) begin
      write_q <= (bus.alu_rd != REG_ZERO);
      if (bus.alu_rd != REG_ZERO) begin
        wr_q <= bus.alu_rd;
        wd_q <= bus.alu_data;
      end
    end else if (pop) begin
      write_q <= (head.rd != REG_ZERO);
      if (head.rd != REG_ZERO) begin
        wr_q <= head.rd;
        wd_q <= head.data;
      end
    end else begin
      write_q <= 1'b0;
    end
  end

  assign bus.stall     = stall;
  assign bus.mem_ready = mem_ready;
  assign bus.write     = write_q;
  assign bus.WR        = wr_q;
  assign bus.WD        = wd_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed vector table plus randomized traffic checked against a queue-based model.
module tb_wb_scoreboard;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_scoreboard_if #(.XLEN(32)) bus ();

  wb_scoreboard #(
    .XLEN     (32),
    .LQ_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        iv, il;
    logic [4:0]  ird, s1, s2;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        e_stall, e_ready, e_write;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic      busy_m [32];
  wb_entry_t mq[$];
  logic        m_write;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, il, input logic [4:0] ird, s1, s2,
                     input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                     input logic es, er, ew, input logic [4:0] ewr, input logic [31:0] ewd);
    vec_t v;
    v.iv = iv; v.il = il; v.ird = ird; v.s1 = s1; v.s2 = s2;
    v.av = av; v.ard = ard; v.ad = ad;
    v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_stall = es; v.e_ready = er; v.e_write = ew; v.e_wr = ewr; v.e_wd = ewd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, il, input logic [4:0] ird, s1, s2,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    bus.issue_valid = iv; bus.issue_long = il; bus.issue_rd = ird;
    bus.src1 = s1; bus.src2 = s2;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    mq.delete();
    m_write = 1'b0; m_wr = '0; m_wd = '0;
  endtask

  task automatic rand_cycle(input int n);
    logic        iv, il, av, mv, es, er;
    logic [4:0]  ird, s1, s2, ard, mrd;
    logic [31:0] ad, md;
    wb_entry_t   h, e;
    iv  = 1'($urandom_range(0, 1));
    il  = 1'($urandom_range(0, 1));
    ird = 5'($urandom_range(0, 7));
    s1  = 5'($urandom_range(0, 7));
    s2  = 5'($urandom_range(0, 7));
    av  = ($urandom_range(0, 2) == 0);
    ard = 5'($urandom_range(0, 7));
    ad  = $urandom;
    mv  = 1'($urandom_range(0, 1));
    mrd = 5'($urandom_range(0, 7));
    md  = $urandom;
    drive(iv, il, ird, s1, s2, av, ard, ad, mv, mrd, md);
    #1;
    es = iv & (busy_m[s1] | busy_m[s2] | busy_m[ird]);
    er = (mq.size() < DEPTH);
    chk($sformatf("r%0d_stall", n), 32'(bus.stall), 32'(es));
    chk($sformatf("r%0d_ready", n), 32'(bus.mem_ready), 32'(er));
    if (av) begin
      m_write = (ard != 0);
      if (ard != 0) begin m_wr = ard; m_wd = ad; end
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_write = (h.rd != 0);
      if (h.rd != 0) begin m_wr = h.rd; m_wd = h.data; busy_m[h.rd] = 1'b0; end
    end else begin
      m_write = 1'b0;
    end
    if (iv && !es && il && ird != 0) busy_m[ird] = 1'b1;
    if (mv && er) begin
      e.rd = mrd; e.data = md;
      mq.push_back(e);
    end
    @(posedge clk); #1;
    chk($sformatf("r%0d_write", n), 32'(bus.write), 32'(m_write));
    chk($sformatf("r%0d_WR", n), 32'(bus.WR), 32'(m_wr));
    chk($sformatf("r%0d_WD", n), bus.WD, m_wd);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state: outputs zero, buffer empty, nothing busy
    drive(1, 0, 5, 5, 5, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_write", 32'(bus.write), 0);
    chk("rst_WR", 32'(bus.WR), 0);
    chk("rst_WD", bus.WD, 0);
    chk("rst_ready", 32'(bus.mem_ready), 1);
    chk("rst_stall", 32'(bus.stall), 0);
    idle();
    @(negedge clk);

    //   iv il ird s1 s2   av ard ad            mv mrd md       stall rdy wr WR WD
    add(0, 0, 0, 0, 0,   1, 3, 32'hDEADBEEF,  0, 0, 0,        0, 1, 1, 3, 32'hDEADBEEF);
    add(0, 0, 0, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 0, 3, 32'hDEADBEEF);
    add(1, 1, 5, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 0, 3, 32'hDEADBEEF);
    add(1, 0, 1, 5, 0,   0, 0, 0,             1, 5, 32'h55,   1, 1, 0, 3, 32'hDEADBEEF);
    add(1, 0, 1, 5, 0,   0, 0, 0,             0, 0, 0,        1, 1, 1, 5, 32'h55);
    add(1, 0, 1, 5, 0,   0, 0, 0,             0, 0, 0,        0, 1, 0, 5, 32'h55);
    add(0, 0, 0, 0, 0,   1, 7, 32'h77,        1, 8, 32'h88,   0, 1, 1, 7, 32'h77);
    add(0, 0, 0, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 1, 8, 32'h88);
    add(0, 0, 0, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 0, 8, 32'h88);
    add(0, 0, 0, 0, 0,   1, 10, 32'hA0,       1, 20, 32'h20,  0, 1, 1, 10, 32'hA0);
    add(0, 0, 0, 0, 0,   1, 11, 32'hA1,       1, 21, 32'h21,  0, 1, 1, 11, 32'hA1);
    add(0, 0, 0, 0, 0,   1, 12, 32'hA2,       1, 22, 32'h22,  0, 0, 1, 12, 32'hA2);
    add(0, 0, 0, 0, 0,   1, 13, 32'hA3,       1, 22, 32'h22,  0, 0, 1, 13, 32'hA3);
    add(0, 0, 0, 0, 0,   0, 0, 0,             1, 22, 32'h22,  0, 0, 1, 20, 32'h20);
    add(0, 0, 0, 0, 0,   0, 0, 0,             1, 22, 32'h22,  0, 1, 1, 21, 32'h21);
    add(0, 0, 0, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 1, 22, 32'h22);
    add(0, 0, 0, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 0, 22, 32'h22);
    add(1, 1, 0, 0, 0,   0, 0, 0,             1, 0, 32'h99,   0, 1, 0, 22, 32'h22);
    add(1, 0, 0, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 0, 22, 32'h22);
    add(1, 1, 9, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 0, 22, 32'h22);
    add(0, 0, 0, 0, 0,   0, 0, 0,             1, 9, 32'h9,    0, 1, 0, 22, 32'h22);
    add(1, 1, 9, 0, 0,   0, 0, 0,             0, 0, 0,        1, 1, 1, 9, 32'h9);
    add(1, 1, 9, 0, 0,   0, 0, 0,             0, 0, 0,        0, 1, 0, 9, 32'h9);
    add(1, 0, 1, 0, 9,   0, 0, 0,             0, 0, 0,        1, 1, 0, 9, 32'h9);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].iv, vecs[i].il, vecs[i].ird, vecs[i].s1, vecs[i].s2,
            vecs[i].av, vecs[i].ard, vecs[i].ad,
            vecs[i].mv, vecs[i].mrd, vecs[i].md);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d_ready", i), 32'(bus.mem_ready), 32'(vecs[i].e_ready));
      @(posedge clk); #1;
      chk($sformatf("v%0d_write", i), 32'(bus.write), 32'(vecs[i].e_write));
      chk($sformatf("v%0d_WR", i), 32'(bus.WR), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_WD", i), bus.WD, vecs[i].e_wd);
      @(negedge clk);
    end

    // Mid-stream asynchronous reset with busy[9] set and a long result buffered
    drive(0, 0, 0, 0, 0, 1, 4, 32'h44, 1, 6, 32'h66);
    @(posedge clk); #1;
    chk("ar_write_pre", 32'(bus.write), 1);
    chk("ar_WR_pre", 32'(bus.WR), 4);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_write", 32'(bus.write), 0);
    chk("ar_WR", 32'(bus.WR), 0);
    chk("ar_WD", bus.WD, 0);
    chk("ar_ready", 32'(bus.mem_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_busy_clr", 32'(bus.stall), 0);
    idle();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ar_discard%0d", k), 32'(bus.write), 0);
    end
    @(negedge clk);

    model_reset();
    for (int n = 0; n < 3000; n++) rand_cycle(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
